moore_1011: RTL and testbench

- Moore-type serial sequence detector for the bit pattern 1-0-1-1 on a single-bit input stream.
- Samples `in` once per rising clock edge and asserts `out` for one cycle after the final `1` of the pattern.
- `out` is a pure function of the registered state, so it has no combinational path from `in`.
- Used as a pattern-recognition leaf block, e.g. for frame or sync-word detection, inside larger control logic.

---
 rtl/moore_1011_pkg.sv | 14 +
 rtl/moore_1011.sv | 47 ++++
 tb/tb_moore_1011.sv | 123 ++++++++++++
 3 files changed

// File: rtl/moore_1011_pkg.sv
// Shared types and constants for the 1-0-1-1 serial sequence detector.
package moore_1011_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3,
        S_1011 = 3'd4
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/moore_1011.sv
// Moore detector for the serial pattern 1-0-1-1; out is decoded from the
// registered state only, so it has no combinational path from in.
module moore_1011
    import moore_1011_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: state_d = in ? S_1    : S_IDLE;
            S_1:    state_d = in ? S_1    : S_10;
            S_10:   state_d = in ? S_101  : S_IDLE;
            S_101:  state_d = in ? S_1011 : S_10;
            // After a match the trailing "1" may seed a new "10" prefix
            // only when overlapping detection is enabled.
            S_1011: begin
                if (in) begin
                    state_d = S_1;
                end else begin
                    state_d = (OVERLAP != 0) ? S_10 : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out = (state_q == S_1011);

endmodule

// File: tb/tb_moore_1011.sv
// Bench for moore_1011: overlapping and non-overlapping instances driven in
// parallel and checked against a sliding-window pattern model.
module tb_moore_1011;
    import moore_1011_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic out_ov;
    logic out_nov;

    int vectors     = 0;
    int miscompares = 0;

    // Reference: last four bits observed since the window was last cleared.
    logic [3:0] win_ov  = 4'd0;
    logic [3:0] win_nov = 4'd0;
    int         cnt_ov  = 0;
    int         cnt_nov = 0;
    logic       exp_ov  = 1'b0;
    logic       exp_nov = 1'b0;

    always #5 clk = ~clk;

    moore_1011 #(.OVERLAP(1)) dut_ov (
        .clk (clk),
        .rst (rst),
        .in  (din),
        .out (out_ov)
    );

    moore_1011 #(.OVERLAP(0)) dut_nov (
        .clk (clk),
        .rst (rst),
        .in  (din),
        .out (out_nov)
    );

    task automatic step(input logic r, input logic b, input string tag);
        @(negedge clk);
        rst = r;
        din = b;
        @(posedge clk);
        if (r) begin
            win_ov  = 4'd0;
            win_nov = 4'd0;
            cnt_ov  = 0;
            cnt_nov = 0;
            exp_ov  = 1'b0;
            exp_nov = 1'b0;
        end else begin
            win_ov  = {win_ov[2:0], b};
            cnt_ov  = cnt_ov + 1;
            exp_ov  = (cnt_ov >= 4) && (win_ov == PATTERN);
            win_nov = {win_nov[2:0], b};
            cnt_nov = cnt_nov + 1;
            exp_nov = (cnt_nov >= 4) && (win_nov == PATTERN);
            if (exp_nov) begin
                win_nov = 4'd0;
                cnt_nov = 0;
            end
        end
        #1;
        vectors++;
        assert (out_ov === exp_ov) else begin
            miscompares++;
            $error("FAIL %s ov: out=%b expected=%b (rst=%b in=%b)", tag, out_ov, exp_ov, r, b);
        end
        vectors++;
        assert (out_nov === exp_nov) else begin
            miscompares++;
            $error("FAIL %s nov: out=%b expected=%b (rst=%b in=%b)", tag, out_nov, exp_nov, r, b);
        end
        $display("step %-8s rst=%b in=%b out_ov=%b/%b out_nov=%b/%b",
                 tag, r, b, out_ov, exp_ov, out_nov, exp_nov);
    endtask

    task automatic run_bits(input logic [31:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, bits[i], tag);
        end
    endtask

    initial begin
        // Reset held two edges with in toggling.
        step(1'b1, 1'b1, "reset");
        step(1'b1, 1'b0, "reset");

        // Basic match.
        run_bits(32'b1011, 4, "basic");
        step(1'b0, 1'b0, "basic");

        // Non-matching stream followed by a long run of ones.
        step(1'b1, 1'b0, "reset");
        run_bits(32'b1001001001, 10, "nomatch");
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, "ones");

        // Overlap: two pulses on OVERLAP=1, one on OVERLAP=0.
        step(1'b1, 1'b0, "reset");
        run_bits(32'b1011011, 7, "overlap");

        // Reset in mid-sequence discards the partial match.
        step(1'b1, 1'b0, "reset");
        run_bits(32'b101, 3, "midrst");
        step(1'b1, 1'b1, "midrst");
        step(1'b0, 1'b1, "midrst");
        step(1'b1, 1'b0, "reset");
        run_bits(32'b1011, 4, "fresh");

        // Runs of ones exercise the S_1 self-loop.
        step(1'b1, 1'b0, "reset");
        run_bits(32'b111011, 6, "runs");

        // Randomized stream, ones-biased, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
